// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage load/store engine. It sits between the ALU/MEM and MEM/WB
// pipeline registers and drives a req/ready handshake to the data RAM.
// Non-memory instructions pass straight through in one cycle. Memory
// instructions are checked for legality and alignment, then issued as a
// single outstanding request. The pipeline is held while that request waits
// for the RAM. A request that waits too long is aborted with a bus-timeout
// exception.
module mem_access_unit #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dataIn,
   input  logic [31:0] dataRs2In,
   input  logic [4:0]  dataCacheControlIn,
   input  logic        writeEnableIn,
   input  logic [4:0]  writeBackAddrIn,
   output logic        stallOut,
   output logic        memReq,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [3:0]  memByteEn,
   output logic [31:0] memWdata,
   input  logic [31:0] memRdata,
   input  logic        memReady,
   output logic [31:0] dataOut,
   output logic        writeEnableOut,
   output logic [4:0]  writeBackAddrOut,
   output logic [1:0]  exceptionOut
);

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   localparam logic [1:0] EXC_NONE    = 2'b00;
   localparam logic [1:0] EXC_MISALGN = 2'b01;
   localparam logic [1:0] EXC_ILLEGAL = 2'b10;
   localparam logic [1:0] EXC_TIMEOUT = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   // Controller state and wait counter
   state_t      state_q;
   logic [7:0]  wait_cnt_q;

   // Registered outputs
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  mem_byte_en_q;
   logic [31:0] mem_wdata_q;
   logic [31:0] data_out_q;
   logic        wb_en_q;
   logic [4:0]  wb_addr_q;
   logic [1:0]  exc_q;

   // Attributes of the access in flight. They are captured at issue so that
   // completion never depends on what upstream presents later.
   logic [2:0]  acc_funct3_q;
   logic [1:0]  acc_lane_q;
   logic        acc_store_q;
   logic        acc_we_q;
   logic [4:0]  acc_rd_q;

   // Decode of the incoming instruction
   logic        is_mem_s;
   logic        is_store_s;
   logic [2:0]  funct3_s;
   logic [1:0]  lane_s;
   logic        legal_s;
   logic        misaligned_s;
   logic [1:0]  exc_code_s;
   logic [3:0]  byte_en_s;
   logic [31:0] lane_data_s;
   logic [31:0] store_data_s;

   // Read-data alignment and handshake status
   logic [31:0] shifted_s;
   logic [31:0] load_data_s;
   logic        timeout_s;
   logic        stall_s;

   assign is_mem_s     = dataCacheControlIn[4];
   assign is_store_s   = dataCacheControlIn[3];
   assign funct3_s     = dataCacheControlIn[2:0];
   assign lane_s       = dataIn[1:0];
   assign store_data_s = is_store_s ? lane_data_s : 32'h0000_0000;
   assign shifted_s    = memRdata >> {acc_lane_q, 3'b000};
   assign timeout_s    = (wait_cnt_q == MAX_WAIT_C);

   // Decode legality, alignment, lane enables and lane-replicated store data.
   always_comb begin
      legal_s      = 1'b0;
      misaligned_s = 1'b0;
      byte_en_s    = 4'b0000;
      lane_data_s  = 32'h0000_0000;
      exc_code_s   = EXC_NONE;

      case (funct3_s)
         3'b000: begin
            legal_s      = 1'b1;
            misaligned_s = 1'b0;
         end
         3'b001: begin
            legal_s      = 1'b1;
            misaligned_s = lane_s[0];
         end
         3'b010: begin
            legal_s      = 1'b1;
            misaligned_s = (lane_s != 2'b00);
         end
         3'b100: begin
            legal_s      = !is_store_s;
            misaligned_s = 1'b0;
         end
         3'b101: begin
            legal_s      = !is_store_s;
            misaligned_s = lane_s[0];
         end
         default: begin
            legal_s      = 1'b0;
            misaligned_s = 1'b0;
         end
      endcase

      // The low two funct3 bits give the access size for both signednesses.
      case (funct3_s[1:0])
         2'b00: begin
            byte_en_s   = 4'b0001 << lane_s;
            lane_data_s = {4{dataRs2In[7:0]}};
         end
         2'b01: begin
            byte_en_s   = lane_s[1] ? 4'b1100 : 4'b0011;
            lane_data_s = {2{dataRs2In[15:0]}};
         end
         2'b10: begin
            byte_en_s   = 4'b1111;
            lane_data_s = dataRs2In;
         end
         default: begin
            byte_en_s   = 4'b0000;
            lane_data_s = 32'h0000_0000;
         end
      endcase

      // An illegal funct3 takes precedence over an alignment fault.
      if (!legal_s) begin
         exc_code_s = EXC_ILLEGAL;
      end else if (misaligned_s) begin
         exc_code_s = EXC_MISALGN;
      end else begin
         exc_code_s = EXC_NONE;
      end
   end

   // Extract the addressed lane from the RAM word and extend it to 32 bits.
   always_comb begin
      load_data_s = 32'h0000_0000;
      case (acc_funct3_q)
         3'b000:  load_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
         3'b001:  load_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
         3'b010:  load_data_s = shifted_s;
         3'b100:  load_data_s = {24'h00_0000, shifted_s[7:0]};
         3'b101:  load_data_s = {16'h0000, shifted_s[15:0]};
         default: load_data_s = 32'h0000_0000;
      endcase
   end

   // Hold upstream while a legal access is being issued or is still waiting.
   // The stall drops in the completion or abort cycle so that upstream can
   // advance on that edge.
   always_comb begin
      stall_s = 1'b0;
      case (state_q)
         ST_IDLE: stall_s = is_mem_s && (exc_code_s == EXC_NONE);
         ST_REQ:  stall_s = !memReady && !timeout_s;
         default: stall_s = 1'b0;
      endcase
   end

   // Access controller: issue, wait/count, complete or abort, with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         wait_cnt_q    <= 8'd0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= 32'h0000_0000;
         mem_byte_en_q <= 4'b0000;
         mem_wdata_q   <= 32'h0000_0000;
         data_out_q    <= 32'h0000_0000;
         wb_en_q       <= 1'b0;
         wb_addr_q     <= 5'd0;
         exc_q         <= EXC_NONE;
         acc_funct3_q  <= 3'b000;
         acc_lane_q    <= 2'b00;
         acc_store_q   <= 1'b0;
         acc_we_q      <= 1'b0;
         acc_rd_q      <= 5'd0;
      end else begin
         // Exceptions are single-cycle pulses unless re-raised below.
         exc_q <= EXC_NONE;
         case (state_q)
            ST_IDLE: begin
               if (!is_mem_s) begin
                  data_out_q <= dataIn;
                  wb_en_q    <= writeEnableIn;
                  wb_addr_q  <= writeBackAddrIn;
               end else if (exc_code_s != EXC_NONE) begin
                  exc_q   <= exc_code_s;
                  wb_en_q <= 1'b0;
               end else begin
                  mem_req_q     <= 1'b1;
                  mem_we_q      <= is_store_s;
                  mem_addr_q    <= {dataIn[31:2], 2'b00};
                  mem_byte_en_q <= byte_en_s;
                  mem_wdata_q   <= store_data_s;
                  wait_cnt_q    <= 8'd0;
                  acc_funct3_q  <= funct3_s;
                  acc_lane_q    <= lane_s;
                  acc_store_q   <= is_store_s;
                  acc_we_q      <= writeEnableIn;
                  acc_rd_q      <= writeBackAddrIn;
                  wb_en_q       <= 1'b0;
                  state_q       <= ST_REQ;
               end
            end
            ST_REQ: begin
               // Completion wins over an abort arriving on the same edge.
               if (memReady) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= ST_IDLE;
                  if (acc_store_q) begin
                     wb_en_q <= 1'b0;
                  end else begin
                     data_out_q <= load_data_s;
                     wb_en_q    <= acc_we_q;
                     wb_addr_q  <= acc_rd_q;
                  end
               end else if (timeout_s) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  exc_q     <= EXC_TIMEOUT;
                  wb_en_q   <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign stallOut         = stall_s;
   assign memReq           = mem_req_q;
   assign memWe            = mem_we_q;
   assign memAddr          = mem_addr_q;
   assign memByteEn        = mem_byte_en_q;
   assign memWdata         = mem_wdata_q;
   assign dataOut          = data_out_q;
   assign writeEnableOut   = wb_en_q;
   assign writeBackAddrOut = wb_addr_q;
   assign exceptionOut     = exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit, built with a short RAM timeout.
// Expected values come from a behavioural model of the load/store rules.
module tb_mem_access_unit;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dataIn;
   logic [31:0] dataRs2In;
   logic [4:0]  dataCacheControlIn;
   logic        writeEnableIn;
   logic [4:0]  writeBackAddrIn;
   logic        stallOut;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [3:0]  memByteEn;
   logic [31:0] memWdata;
   logic [31:0] memRdata;
   logic        memReady;
   logic [31:0] dataOut;
   logic        writeEnableOut;
   logic [4:0]  writeBackAddrOut;
   logic [1:0]  exceptionOut;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst), .dataIn(dataIn), .dataRs2In(dataRs2In),
      .dataCacheControlIn(dataCacheControlIn), .writeEnableIn(writeEnableIn),
      .writeBackAddrIn(writeBackAddrIn), .stallOut(stallOut), .memReq(memReq),
      .memWe(memWe), .memAddr(memAddr), .memByteEn(memByteEn), .memWdata(memWdata),
      .memRdata(memRdata), .memReady(memReady), .dataOut(dataOut),
      .writeEnableOut(writeEnableOut), .writeBackAddrOut(writeBackAddrOut),
      .exceptionOut(exceptionOut)
   );

   // ---------------- behavioural model ----------------
   function automatic int m_size(input logic [2:0] f3);
      return 1 << (int'(f3) % 4);
   endfunction

   function automatic logic [1:0] m_exc(input logic st, input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3'd3 || f3 > 3'd5 || (st && f3 > 3'd2)) return 2'b10;
      if (int'(a[1:0]) % m_size(f3) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int v;
      v = ((1 << m_size(f3)) - 1) << int'(a[1:0]);
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic st, input logic [2:0] f3, input logic [31:0] r2);
      if (!st) return 32'h0;
      if (m_size(f3) == 1) return {24'h0, r2[7:0]} * 32'h0101_0101;
      if (m_size(f3) == 2) return {16'h0, r2[15:0]} * 32'h0001_0001;
      return r2;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      longint v;
      int     sz;
      int     bits;
      sz   = m_size(f3);
      bits = 8 * sz;
      v    = {32'h0, rd};
      v    = v >> (8 * int'(a[1:0]));
      if (sz < 4) begin
         v = v % (64'd1 << bits);
         if (f3 < 3'd4 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
      end
      return v[31:0];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] r2,
                         input logic w, input logic [4:0] rd);
      dataCacheControlIn = c;
      dataIn             = a;
      dataRs2In          = r2;
      writeEnableIn      = w;
      writeBackAddrIn    = rd;
   endtask

   // Run the instruction currently on the inputs until the unit is idle again.
   // memReady stays low for 'lat' request cycles, then is raised with 'rdata'.
   // Only measures: cycle counts and the bus values seen on the first request cycle.
   task automatic run_access(input int lat, input logic [31:0] rdata,
                             output int stall_cyc, output int req_cyc,
                             output logic [31:0] s_addr, output logic [3:0] s_be,
                             output logic [31:0] s_wdata, output logic s_we, output logic held);
      stall_cyc = 0;
      req_cyc   = 0;
      held      = 1'b1;
      s_addr    = 32'h0;
      s_be      = 4'h0;
      s_wdata   = 32'h0;
      s_we      = 1'b0;
      memReady  = 1'b0;
      memRdata  = 32'h0;
      #1;
      if (stallOut === 1'b1) stall_cyc++;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (memReq !== 1'b1) break;
         req_cyc++;
         if (req_cyc == 1) begin
            s_addr = memAddr; s_be = memByteEn; s_wdata = memWdata; s_we = memWe;
         end else if (memAddr !== s_addr || memByteEn !== s_be || memWdata !== s_wdata || memWe !== s_we) begin
            held = 1'b0;
         end
         if (req_cyc > lat) begin
            memReady = 1'b1; memRdata = rdata;
         end else begin
            memReady = 1'b0; memRdata = $urandom();
         end
         #1;
         if (stallOut === 1'b1) stall_cyc++;
      end
      memReady = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      set_op(5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
      memReady = 1'b0; memRdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if ({memReq, memWe, memAddr, memByteEn, memWdata} !== 70'h0) begin n_fail++;
         $display("FAIL reset_mem got req=%b we=%b addr=%h be=%b wd=%h exp all 0", memReq, memWe, memAddr, memByteEn, memWdata); end
      n_checks++; if ({dataOut, writeEnableOut, writeBackAddrOut, exceptionOut} !== 40'h0) begin n_fail++;
         $display("FAIL reset_wb got d=%h we=%b rd=%0d exc=%b exp all 0", dataOut, writeEnableOut, writeBackAddrOut, exceptionOut); end
      n_checks++; if (stallOut !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stallOut); end
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      int sc, rc; logic [31:0] sa, sw; logic [3:0] sb; logic swe, sh;
      set_op(5'd0, 32'h0000_1234, 32'h0, 1'b1, 5'd5);
      run_access(0, 32'h0, sc, rc, sa, sb, sw, swe, sh);
      n_checks++; if (sc != 0 || rc != 0) begin n_fail++; $display("FAIL add_stall got stall=%0d req=%0d exp 0/0", sc, rc); end
      n_checks++; if (dataOut !== 32'h1234) begin n_fail++; $display("FAIL add_data got %h exp 00001234", dataOut); end
      n_checks++; if (writeEnableOut !== 1'b1 || writeBackAddrOut !== 5'd5) begin n_fail++;
         $display("FAIL add_wb got we=%b rd=%0d exp 1/5", writeEnableOut, writeBackAddrOut); end
   endtask

   task automatic test_load_byte();
      int sc, rc; logic [31:0] sa, sw; logic [3:0] sb; logic swe, sh;
      set_op(5'b10000, 32'h0000_0103, 32'h0, 1'b1, 5'd9);
      run_access(3, 32'h80FF_EE11, sc, rc, sa, sb, sw, swe, sh);
      n_checks++; if (sa !== 32'h100 || sb !== 4'b1000 || swe !== 1'b0 || sw !== 32'h0) begin n_fail++;
         $display("FAIL lb_bus got addr=%h be=%b we=%b wd=%h exp 100/1000/0/0", sa, sb, swe, sw); end
      n_checks++; if (sc != 4 || rc != 4 || !sh) begin n_fail++; $display("FAIL lb_cycles got stall=%0d req=%0d held=%b exp 4/4/1", sc, rc, sh); end
      n_checks++; if (dataOut !== 32'hFFFF_FF80 || writeEnableOut !== 1'b1 || writeBackAddrOut !== 5'd9) begin n_fail++;
         $display("FAIL lb_result got d=%h we=%b rd=%0d exp ffffff80/1/9", dataOut, writeEnableOut, writeBackAddrOut); end
      set_op(5'b10100, 32'h0000_0103, 32'h0, 1'b1, 5'd9);
      run_access(3, 32'h80FF_EE11, sc, rc, sa, sb, sw, swe, sh);
      n_checks++; if (dataOut !== 32'h0000_0080 || sc != 4) begin n_fail++;
         $display("FAIL lbu_result got d=%h stall=%0d exp 00000080/4", dataOut, sc); end
   endtask

   task automatic test_store_half();
      int sc, rc; logic [31:0] sa, sw; logic [3:0] sb; logic swe, sh;
      set_op(5'b11001, 32'h0000_0202, 32'hDEAD_BEEF, 1'b1, 5'd3);
      run_access(1, 32'h1111_2222, sc, rc, sa, sb, sw, swe, sh);
      n_checks++; if (sa !== 32'h200 || sb !== 4'b1100 || swe !== 1'b1 || sw !== 32'hBEEF_BEEF) begin n_fail++;
         $display("FAIL sh_bus got addr=%h be=%b we=%b wd=%h exp 200/1100/1/beefbeef", sa, sb, swe, sw); end
      n_checks++; if (writeEnableOut !== 1'b0 || rc != 2 || sc != 2) begin n_fail++;
         $display("FAIL sh_wb got we=%b req=%0d stall=%0d exp 0/2/2", writeEnableOut, rc, sc); end
   endtask

   task automatic test_exceptions();
      int sc, rc; logic [31:0] sa, sw; logic [3:0] sb; logic swe, sh;
      set_op(5'd0, 32'h55, 32'h0, 1'b1, 5'd4);
      run_access(0, 32'h0, sc, rc, sa, sb, sw, swe, sh);
      set_op(5'b10010, 32'h0000_0101, 32'h0, 1'b1, 5'd4);
      run_access(0, 32'h0, sc, rc, sa, sb, sw, swe, sh);
      n_checks++; if (exceptionOut !== 2'b01 || rc != 0 || sc != 0 || writeEnableOut !== 1'b0) begin n_fail++;
         $display("FAIL misalign got exc=%b req=%0d stall=%0d we=%b exp 01/0/0/0", exceptionOut, rc, sc, writeEnableOut); end
      set_op(5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
      run_access(0, 32'h0, sc, rc, sa, sb, sw, swe, sh);
      n_checks++; if (exceptionOut !== 2'b00) begin n_fail++; $display("FAIL exc_pulse got %b exp 00", exceptionOut); end
      set_op(5'b11100, 32'h0000_0040, 32'h1234, 1'b1, 5'd2);
      run_access(0, 32'h0, sc, rc, sa, sb, sw, swe, sh);
      n_checks++; if (exceptionOut !== 2'b10 || rc != 0 || sc != 0) begin n_fail++;
         $display("FAIL illegal got exc=%b req=%0d stall=%0d exp 10/0/0", exceptionOut, rc, sc); end
   endtask

   task automatic test_timeout();
      int sc, rc; logic [31:0] sa, sw; logic [3:0] sb; logic swe, sh;
      set_op(5'b10010, 32'h0000_0400, 32'h0, 1'b1, 5'd6);
      run_access(100, 32'h0, sc, rc, sa, sb, sw, swe, sh);
      n_checks++; if (rc != MAXW + 1 || sc != MAXW + 1) begin n_fail++;
         $display("FAIL timeout_cycles got req=%0d stall=%0d exp %0d/%0d", rc, sc, MAXW + 1, MAXW + 1); end
      n_checks++; if (exceptionOut !== 2'b11 || writeEnableOut !== 1'b0) begin n_fail++;
         $display("FAIL timeout_exc got exc=%b we=%b exp 11/0", exceptionOut, writeEnableOut); end
      set_op(5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
      run_access(0, 32'h0, sc, rc, sa, sb, sw, swe, sh);
      n_checks++; if (exceptionOut !== 2'b00) begin n_fail++; $display("FAIL timeout_pulse got %b exp 00", exceptionOut); end
      set_op(5'b10010, 32'h0000_0404, 32'h0, 1'b1, 5'd6);
      run_access(MAXW, 32'hCAFE_F00D, sc, rc, sa, sb, sw, swe, sh);
      n_checks++; if (rc != MAXW + 1 || exceptionOut !== 2'b00 || dataOut !== 32'hCAFE_F00D || writeEnableOut !== 1'b1) begin n_fail++;
         $display("FAIL limit_ready got req=%0d exc=%b d=%h we=%b exp %0d/00/cafef00d/1", rc, exceptionOut, dataOut, writeEnableOut, MAXW + 1); end
   endtask

   task automatic test_random();
      int sc, rc; logic [31:0] sa, sw; logic [3:0] sb; logic swe, sh;
      int kind, lat, r, exp_req, exp_stall;
      logic [2:0] f3; logic [31:0] a, r2, rdat; logic w, st; logic [4:0] rd; logic [1:0] e;
      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 2);
         f3   = 3'($urandom_range(0, 7));
         a    = $urandom();
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         r2   = $urandom(); rdat = $urandom();
         w    = 1'($urandom_range(0, 1)); rd = 5'($urandom_range(0, 31));
         r    = $urandom_range(0, 9);
         lat  = (r < 7) ? (r % 4) : ((r == 7) ? MAXW : MAXW + 4);
         st   = (kind == 2) ? 1'b1 : ((kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
         set_op({(kind != 0), st, f3}, a, r2, w, rd);
         run_access(lat, rdat, sc, rc, sa, sb, sw, swe, sh);
         e = (kind == 0) ? 2'b00 : m_exc(st, f3, a);
         if (kind == 0 || e != 2'b00) begin
            exp_req = 0; exp_stall = 0;
         end else begin
            exp_req   = (lat > MAXW) ? MAXW + 1 : lat + 1;
            exp_stall = 1 + ((lat > MAXW) ? MAXW : lat);
            if (lat > MAXW) e = 2'b11;
         end
         n_checks++; if (rc != exp_req || sc != exp_stall) begin n_fail++;
            $display("FAIL rnd_cycles i=%0d got req=%0d stall=%0d exp %0d/%0d", i, rc, sc, exp_req, exp_stall); end
         n_checks++; if (exceptionOut !== e) begin n_fail++; $display("FAIL rnd_exc i=%0d got %b exp %b", i, exceptionOut, e); end
         if (exp_req > 0) begin
            n_checks++; if (sa !== {a[31:2], 2'b00} || sb !== m_be(f3, a) || sw !== m_wdata(st, f3, r2) || swe !== st || !sh) begin n_fail++;
               $display("FAIL rnd_bus i=%0d got addr=%h be=%b wd=%h we=%b held=%b exp %h/%b/%h/%b/1", i, sa, sb, sw, swe, sh,
                        {a[31:2], 2'b00}, m_be(f3, a), m_wdata(st, f3, r2), st); end
         end
         if (kind == 0) begin
            n_checks++; if (dataOut !== a || writeEnableOut !== w || writeBackAddrOut !== rd) begin n_fail++;
               $display("FAIL rnd_pass i=%0d got d=%h we=%b rd=%0d exp %h/%b/%0d", i, dataOut, writeEnableOut, writeBackAddrOut, a, w, rd); end
         end else if (kind == 1 && e == 2'b00) begin
            n_checks++; if (dataOut !== m_load(f3, a, rdat) || writeEnableOut !== w || writeBackAddrOut !== rd) begin n_fail++;
               $display("FAIL rnd_load i=%0d f3=%0d got d=%h we=%b rd=%0d exp %h/%b/%0d", i, f3, dataOut, writeEnableOut, writeBackAddrOut,
                        m_load(f3, a, rdat), w, rd); end
         end else begin
            n_checks++; if (writeEnableOut !== 1'b0) begin n_fail++; $display("FAIL rnd_nowb i=%0d got we=%b exp 0", i, writeEnableOut); end
         end
      end
   endtask

   task automatic test_reset_in_req();
      set_op(5'b10010, 32'h0000_0300, 32'h0, 1'b1, 5'd7);
      memReady = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      n_checks++; if (memReq !== 1'b1 || memByteEn !== 4'b1111) begin n_fail++;
         $display("FAIL rstreq_pending got req=%b be=%b exp 1/1111", memReq, memByteEn); end
      rst = 1'b1; memReady = 1'b1; memRdata = 32'h1234_5678;
      @(posedge clk); #1;
      n_checks++; if ({memReq, memWe, memAddr, memByteEn, memWdata} !== 70'h0) begin n_fail++;
         $display("FAIL rstreq_mem got req=%b we=%b addr=%h be=%b wd=%h exp all 0", memReq, memWe, memAddr, memByteEn, memWdata); end
      n_checks++; if ({dataOut, writeEnableOut, writeBackAddrOut, exceptionOut} !== 40'h0) begin n_fail++;
         $display("FAIL rstreq_wb got d=%h we=%b rd=%0d exc=%b exp all 0", dataOut, writeEnableOut, writeBackAddrOut, exceptionOut); end
      rst = 1'b0;
      set_op(5'd0, 32'h0, 32'h0, 1'b0, 5'd0);
      repeat (2) begin
         @(posedge clk); #1;
         n_checks++; if (writeEnableOut !== 1'b0 || memReq !== 1'b0 || dataOut !== 32'h0) begin n_fail++;
            $display("FAIL rstreq_late got we=%b req=%b d=%h exp 0/0/0", writeEnableOut, memReq, dataOut); end
      end
      memReady = 1'b0;
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_load_byte();
      test_store_half();
      test_exceptions();
      test_timeout();
      test_random();
      test_reset_in_req();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog got no end of test exp finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine sitting directly downstream of the ALU/MEM pipeline register and upstream of the MEM/WB register.
- Consumes the registered ALU result (address or passthrough data), the rs2 store data, the memory control bundle and the write-back tag.
- Runs a multi-cycle req/ready handshake with the data RAM, performs byte-lane alignment, sign/zero extension and misalignment/timeout detection, and stalls the pipeline while an access is in flight.

Parameters:
- MAX_WAIT, 255: cycles REQ may wait for memReady before a bus-error abort (counter width 8).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- dataIn  in  32  ALU result: effective address for memory ops, passthrough value otherwise
- dataRs2In  in  32  store data
- dataCacheControlIn  in  5  [4]=access enable, [3]=write (store), [2:0]=RISC-V funct3
- writeEnableIn  in  1  register write-back request
- writeBackAddrIn  in  5  rd index
- stallOut  out  1  holds upstream stages; upstream keeps all inputs stable while high
- memReq  out  1  RAM request, registered
- memWe  out  1  RAM write strobe, registered
- memAddr  out  32  word address, {dataIn[31:2],2'b00}, registered
- memByteEn  out  4  byte lane enables, registered
- memWdata  out  32  lane-replicated store data, registered
- memRdata  in  32  RAM read data, valid when memReady=1
- memReady  in  1  RAM completion, sampled at clock edges
- dataOut  out  32  to MEM/WB: load result or passthrough, registered
- writeEnableOut  out  1  to MEM/WB, registered
- writeBackAddrOut  out  5  to MEM/WB, registered
- exceptionOut  out  2  one-cycle pulse: 00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout

Behaviour:
- Reset (synchronous): state=IDLE, wait counter=0; memReq, memWe, memByteEn, memAddr, memWdata, dataOut, writeEnableOut, writeBackAddrOut and exceptionOut all 0. A reset during REQ aborts the access; a memReady arriving on the same or a later edge is ignored.
- FSM states are IDLE and REQ.
- IDLE, non-memory op (ctrl[4]=0):
  - dataOut<=dataIn, writeEnableOut<=writeEnableIn, writeBackAddrOut<=writeBackAddrIn on the next edge.
  - stallOut=0. Latency is 1 cycle.
- IDLE, memory op: check legality and alignment combinationally.
  - Legal loads: funct3 000 (LB), 001 (LH), 010 (LW), 100 (LBU), 101 (LHU).
  - Legal stores: 000, 001, 010.
  - Any other funct3 raises exception 10.
  - Misaligned if halfword with addr[0]=1, or word with addr[1:0]!=0; raises exception 01.
  - Any exception: pulse exceptionOut for one cycle, writeEnableOut<=0, no RAM request, stallOut=0, stay IDLE.
  - Otherwise: stallOut=1 and, at the edge, load memReq=1, memWe=ctrl[3], memAddr, memByteEn and memWdata; clear the counter and go to REQ. writeEnableOut<=0 (bubble).
- Byte enables and store data:
  - Byte: memByteEn = 1<<addr[1:0]; memWdata = {4{rs2[7:0]}}.
  - Half: memByteEn = addr[1] ? 1100 : 0011; memWdata = {2{rs2[15:0]}}.
  - Word: memByteEn = 1111; memWdata = rs2.
  - For loads, memByteEn is the same pattern and memWdata=0.
- REQ: memory outputs hold constant.
  - stallOut = !memReady.
  - Each edge with memReady=0 increments the counter.
- REQ, edge with memReady=1: memReq<=0, go to IDLE.
  - Load: dataOut <= memRdata shifted right by addr[1:0]*8, then sign-extended (LB/LH) or zero-extended (LBU/LHU) from 8/16 bits; LW passes all 32 bits. writeEnableOut<=writeEnableIn, writeBackAddrOut<=writeBackAddrIn.
  - Store: writeEnableOut<=0 regardless of writeEnableIn.
  - Because stallOut falls in this cycle, upstream advances on the same edge. The next instruction is therefore evaluated in IDLE on the following cycle with no gap.
- REQ, counter==MAX_WAIT with memReady=0 at the edge: abort.
  - memReq<=0, exceptionOut<=11 for one cycle, writeEnableOut<=0, go to IDLE.
  - stallOut is 0 in the abort cycle.
  - memReady=1 in the abort cycle takes priority, and the access completes normally.
- Rule: memReq never deasserts before memReady or abort. At most one outstanding access.

Test Plan:
- ADD passthrough: dataIn=0x1234, we=1, rd=5, ctrl=0 -> next cycle dataOut=0x1234, writeEnableOut=1, writeBackAddrOut=5; stallOut stays 0.
- LB at 0x103, memRdata=0x80FFEE11, memReady after 3 cycles -> memAddr=0x100, memByteEn=1000, stallOut high 4 cycles; dataOut=0xFFFFFF80, writeEnableOut=1. Repeat with LBU -> dataOut=0x00000080.
- SH at 0x202, rs2=0xDEADBEEF -> memWe=1, memByteEn=1100, memWdata=0xBEEFBEEF; writeEnableOut=0 even with writeEnableIn=1.
- LW at 0x101 -> exceptionOut=01 for 1 cycle, memReq never rises, writeEnableOut=0. Store with funct3=100 -> exceptionOut=10.
- MAX_WAIT=4, memReady held low -> memReq high exactly 5 cycles, then exceptionOut=11 and stallOut=0. Second run: memReady=1 on the limit edge -> normal completion, no exception.
- rst pulsed for 1 cycle in REQ -> memReq=0 and all outputs 0 next cycle; a later memReady=1 produces no write-back.
